// File: rtl/unidade_controle_rodada.sv
// Round control unit for the memory-match game: Moore FSM sequencing the
// address counter, chaves register and comparator, with a per-move inactivity timeout.
module unidade_controle_rodada #(
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int TW             = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registro,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  estado_t        estado, proximo;
  logic           jogada_ant;
  logic           borda;
  logic           limite;
  logic [TW-1:0]  cont_timeout;

  // One borda per press: a held chave never retriggers.
  assign borda  = jogada & ~jogada_ant;
  assign limite = (cont_timeout == TW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      jogada_ant   <= 1'b0;
      cont_timeout <= '0;
    end else begin
      estado     <= proximo;
      jogada_ant <= jogada;
      // Counts only while staying in ESPERA, so it clears on any exit and never wraps.
      if (estado == ESPERA && proximo == ESPERA)
        cont_timeout <= cont_timeout + TW'(1);
      else
        cont_timeout <= '0;
    end
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:  proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:  proximo = ESPERA;
      ESPERA: begin
        if (borda)       proximo = REGISTRA;
        else if (limite) proximo = FIM_TIMEOUT;
        else             proximo = ESPERA;
      end
      REGISTRA: proximo = COMPARA;
      COMPARA: begin
        if (!igual)            proximo = FIM_ERROU;
        else if (fim_contagem) proximo = FIM_ACERTOU;
        else                   proximo = PROXIMO;
      end
      PROXIMO:  proximo = ESPERA;
      FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
        proximo = iniciar ? PREPARA : estado;
      default:  proximo = INICIAL;
    endcase
  end

  always_comb begin
    zera_contador  = 1'b0;
    conta_contador = 1'b0;
    zera_registro  = 1'b0;
    registra       = 1'b0;
    pronto         = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    timeout        = 1'b0;
    case (estado)
      PREPARA: begin
        zera_contador = 1'b1;
        zera_registro = 1'b1;
      end
      REGISTRA:    registra       = 1'b1;
      PROXIMO:     conta_contador = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
